cic_comp_fir: RTL and testbench
===============================

Name: cic_comp_fir

Overview:
Compensation FIR with decimate-by-2, placed directly downstream of cic_decim in the receive decimation chain.
- Flattens CIC passband droop and halves the sample rate.
- Uses one serial multiply-accumulate (MAC), one tap per clock, over a circular sample buffer.
- Input side is valid-only with no backpressure, matching cic_decim's output. Rate violations are flagged, never stalled.

Parameters:
WIDTH, 8, signed sample width of input and output
COEF_WIDTH, 16, signed coefficient width, Q1.(COEF_WIDTH-1)
NUM_TAPS, 16, filter length; power of 2, at least 4

Ports:
i_clock  in  1  clock
i_reset  in  1  reset
i_in_data  in  WIDTH  signed sample from cic_decim
i_in_valid  in  1  sample qualifier
o_out_data  out  WIDTH  signed filtered, decimated sample
o_out_valid  out  1  one-cycle output strobe
o_overrun  out  1  sticky flag: a compute trigger arrived while busy

Behaviour:
- Clock i_clock; reset i_reset, synchronous, active-high.
- Reset values:
  - o_out_data=0, o_out_valid=0, o_overrun=0.
  - Buffer contents cleared to 0; write pointer=0; phase=0; state=IDLE.
- Sample buffer:
  - Depth 2*NUM_TAPS, circular.
  - Every i_in_valid writes at wptr, then wptr increments modulo 2*NUM_TAPS. Wrap is silent.
  - Writes are always accepted, in every state.
- Phase toggles on every valid input. An input that sets phase 0->1 does not trigger; 1->0 is a trigger.
  - The 2nd, 4th, 6th, ... valid input after reset triggers a computation.
- FSM states: IDLE, MAC, ROUND.
  - IDLE: on trigger, latch base = address of the triggering sample and clear acc; go to MAC with k=0.
  - MAC: each cycle acc += buf[base-k mod 2N] * COEF[k]. After k=NUM_TAPS-1, go to ROUND.
  - ROUND: acc + 2^(COEF_WIDTH-2), arithmetic shift right by COEF_WIDTH-1, saturate to WIDTH signed range. Register to o_out_data, pulse o_out_valid for 1 cycle, return to IDLE.
- Latency: o_out_valid is high exactly NUM_TAPS+2 cycles after the edge capturing the triggering input.
- o_out_data holds its value between strobes.
- Accumulator width: WIDTH+COEF_WIDTH+clog2(NUM_TAPS) signed; no internal overflow is possible.
- Buffer depth 2N guarantees samples written during MAC never overwrite taps still being read.
- Overrun:
  - A trigger in MAC or ROUND is not computed; that output is dropped; o_overrun is set.
  - The in-flight computation completes normally.
  - The sample is still written.
  - o_overrun clears only on reset.
- Legal rate: trigger spacing at least NUM_TAPS+2 cycles, i.e. input spacing at least (NUM_TAPS+2)/2 cycles.
- Trigger in the same cycle the FSM is in ROUND counts as overrun. A trigger one cycle later (state is IDLE) is accepted.
- Reset mid-computation:
  - Abandons the computation; no o_out_valid.
  - All state returns to reset values the next cycle.

Decomposition:
- Package cic_comp_pkg holds:
  - localparam COEF_WIDTH_DEFAULT;
  - typedef coef_t (signed COEF_WIDTH);
  - fsm enum state_t {IDLE, MAC, ROUND};
  - constant array CIC_COMP_COEFS[16]: symmetric, sum exactly 32768 (unity DC gain).
- Sub-module fir_sat_round: combinational round-half-up, shift and saturate, shared with later decimation stages.
- Buffer is an inferred RAM, one write port and one read port, inside the top module.

Test Plan:
- Reset then 32 inputs of constant 50, spaced 10 cycles -> outputs settle to 50 once the buffer is full (8th output onward); o_overrun=0.
- Impulse 64 at input 1, zeros after, 10-cycle spacing -> output j equals round(64*COEF[2j-1]/32768), j=1..8; latency NUM_TAPS+2=18 cycles from each trigger.
- Constant +127, then constant -128 -> steady outputs 127 and -128; with a test coefficient set of DC gain 2, outputs saturate at 127/-128, no wrap.
- Inputs every cycle -> trigger at input 4 arrives while busy: o_overrun=1 and stays 1; first output still correct.
- Assert i_reset 5 cycles into MAC -> no o_out_valid; next 2 inputs after release produce an output whose buffer history is all zeros except those 2 samples.
- 200 inputs at legal spacing -> wptr wraps several times; outputs match the golden model bit-exactly.

Source files
------------

// File: rtl/cic_comp_pkg.sv
// Shared types and constants for the CIC compensation FIR.
// The default coefficient set is symmetric and sums to exactly 32768,
// so a DC input passes with unity gain in Q1.15.
package cic_comp_pkg;

    localparam int COEF_WIDTH_DEFAULT = 16;
    localparam int NUM_COEFS          = 16;

    typedef logic signed [COEF_WIDTH_DEFAULT-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2
    } state_t;

    // Negative outer taps and a raised centre lift the upper passband to
    // cancel the sinc droop of the preceding CIC.
    localparam coef_t CIC_COMP_COEFS [NUM_COEFS] = '{
        -16'sd64,  -16'sd128,  16'sd128,  16'sd512,
         16'sd768,  16'sd1792, 16'sd4992, 16'sd8384,
         16'sd8384, 16'sd4992, 16'sd1792, 16'sd768,
         16'sd512,  16'sd128, -16'sd128, -16'sd64
    };

endpackage

// File: rtl/fir_sat_round.sv
// Combinational round-half-up, arithmetic right shift and saturation.
// Used to bring a wide accumulator back to the sample width.
module fir_sat_round #(
    parameter int IN_W  = 28,
    parameter int SHIFT = 15,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic signed [OUT_W-1:0] out_o
);

    // Half an output LSB, added before the shift so ties round upward.
    localparam logic signed [IN_W:0] HALF  = {{(IN_W+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [IN_W:0] MAX_V = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0] biased;
    logic signed [IN_W:0] shifted;

    // One guard bit keeps the rounding add from overflowing before the clamp.
    always_comb begin
        biased  = $signed({in_i[IN_W-1], in_i}) + HALF;
        shifted = biased >>> SHIFT;
        if (shifted > MAX_V) begin
            out_o = MAX_V[OUT_W-1:0];
        end else if (shifted < MIN_V) begin
            out_o = MIN_V[OUT_W-1:0];
        end else begin
            out_o = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/cic_comp_fir.sv
// CIC droop compensation FIR with decimate-by-2.
// Every valid input lands in a circular buffer of 2*NUM_TAPS samples; every
// second input starts a serial MAC (one tap per clock) over the newest
// NUM_TAPS samples. A start request while a result is in flight is dropped
// and latched in the sticky overrun flag.
//
// Input handshake: i_in_valid qualifies i_in_data for exactly the cycle it is
// high; there is no ready, so every qualified sample is written. o_out_valid
// is a one-cycle strobe and o_out_data holds its value between strobes.
//
// Timing from the edge that captures a triggering sample (E0):
//   E1..E16  MAC state issues buffer reads k=0..NUM_TAPS-1 (registered read)
//   E2..E17  products accumulate one clock behind the reads
//   E16      state enters ROUND, E17 back to IDLE (next trigger accepted at E17+1)
//   E18      rounded/saturated result registered, o_out_valid high
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int COEF_WIDTH = COEF_WIDTH_DEFAULT,
    parameter int NUM_TAPS   = 16,
    parameter logic signed [COEF_WIDTH-1:0] COEFS [NUM_TAPS] = CIC_COMP_COEFS
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic signed [WIDTH-1:0] i_in_data,
    input  logic                    i_in_valid,
    output logic signed [WIDTH-1:0] o_out_data,
    output logic                    o_out_valid,
    output logic                    o_overrun
);

    localparam int DEPTH  = 2 * NUM_TAPS;
    localparam int AW     = $clog2(DEPTH);
    localparam int KW     = $clog2(NUM_TAPS);
    localparam int PROD_W = WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + KW;

    localparam logic [KW-1:0] K_LAST = KW'(NUM_TAPS - 1);

    // FSM
    state_t state_q;
    state_t state_d;
    logic   start;
    logic   mac_rd;
    logic   round_go;

    // Input side
    logic          phase_q;
    logic [AW-1:0] wptr_q;
    logic          overrun_q;
    logic          trigger;

    // Sample buffer and read port
    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]           base_q;
    logic [KW-1:0]           k_q;
    logic [AW-1:0]           rd_addr;
    logic signed [WIDTH-1:0] rd_q;
    logic [KW-1:0]           rd_k_q;
    logic                    rd_v_q;

    // Datapath
    logic signed [COEF_WIDTH-1:0] coef_sel;
    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_W-1:0]      prod_ext;
    logic signed [ACC_W-1:0]      acc_q;
    logic                         round_pend_q;
    logic signed [WIDTH-1:0]      sat_out;
    logic signed [WIDTH-1:0]      out_data_q;
    logic                         out_valid_q;

    // The second of each pair of valid inputs requests a computation.
    assign trigger = i_in_valid & phase_q;

    // Taps walk backwards from the triggering sample.
    assign rd_addr = base_q - {1'b0, k_q};

    assign coef_sel = COEFS[rd_k_q];
    assign prod     = rd_q * coef_sel;
    assign prod_ext = {{KW{prod[PROD_W-1]}}, prod};

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        mac_rd   = 1'b0;
        round_go = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    start   = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                mac_rd = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                round_go = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Decimation phase, write pointer and sticky overrun flag.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            phase_q   <= 1'b0;
            wptr_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (i_in_valid) begin
                phase_q <= ~phase_q;
                wptr_q  <= wptr_q + 1'b1;
            end
            if (trigger && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Buffer write port: every qualified sample is stored, in any state.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_in_valid) begin
            mem_q[wptr_q] <= i_in_data;
        end
    end

    // Buffer read port, registered along with the tap index it belongs to.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rd_q   <= '0;
            rd_k_q <= '0;
            rd_v_q <= 1'b0;
        end else begin
            rd_q   <= mem_q[rd_addr];
            rd_k_q <= k_q;
            rd_v_q <= mac_rd;
        end
    end

    // Tap counter and base address of the current window.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            k_q    <= '0;
            base_q <= '0;
        end else if (start) begin
            k_q    <= '0;
            base_q <= wptr_q;
        end else if (mac_rd) begin
            k_q <= k_q + 1'b1;
        end
    end

    // Accumulator: cleared on start, one product per clock behind the reads.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc_q <= '0;
        end else if (start) begin
            acc_q <= '0;
        end else if (rd_v_q) begin
            acc_q <= acc_q + prod_ext;
        end
    end

    fir_sat_round #(
        .IN_W  (ACC_W),
        .SHIFT (COEF_WIDTH - 1),
        .OUT_W (WIDTH)
    ) u_sat_round (
        .in_i  (acc_q),
        .out_o (sat_out)
    );

    // Output stage: the edge after ROUND, when the last product has landed.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            round_pend_q <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            round_pend_q <= round_go;
            out_valid_q  <= round_pend_q;
            if (round_pend_q) begin
                out_data_q <= sat_out;
            end
        end
    end

    assign o_out_data  = out_data_q;
    assign o_out_valid = out_valid_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: reset values, DC settling, impulse
// response with latency, saturation, overrun, reset mid-computation, and a
// long run compared against a reference model of the filter equation.
module tb_cic_comp_fir;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] i_data = 8'd0;
    logic       i_valid = 1'b0;

    logic signed [7:0] o_data;
    logic              o_valid;
    logic              o_overrun;
    logic signed [7:0] o_data2;
    logic              o_valid2;
    logic              o_overrun2;

    // Same filter shape with every coefficient doubled: DC gain of 2.
    localparam logic signed [15:0] COEFS2 [16] = '{
        -16'sd128, -16'sd256,  16'sd256,  16'sd1024,
         16'sd1536, 16'sd3584, 16'sd9984, 16'sd16768,
         16'sd16768, 16'sd9984, 16'sd3584, 16'sd1536,
         16'sd1024, 16'sd256, -16'sd256, -16'sd128
    };

    int coef [16] = '{-64, -128, 128, 512, 768, 1792, 4992, 8384,
                      8384, 4992, 1792, 768, 512, 128, -128, -64};

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_in = 0;
    int         hist [$];
    int         out_q [$];
    int         out2_q [$];
    int         ocyc_q [$];
    int         trig_q [$];
    logic [7:0] exp_q [$];

    cic_comp_fir u_dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_in_data   (i_data),
        .i_in_valid  (i_valid),
        .o_out_data  (o_data),
        .o_out_valid (o_valid),
        .o_overrun   (o_overrun)
    );

    cic_comp_fir #(.COEFS(COEFS2)) u_dut2 (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_in_data   (i_data),
        .i_in_valid  (i_valid),
        .o_out_data  (o_data2),
        .o_out_valid (o_valid2),
        .o_overrun   (o_overrun2)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output capture, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && o_valid) begin
            out_q.push_back(int'(o_data));
            ocyc_q.push_back(cyc);
        end
        if (!rst && o_valid2) begin
            out2_q.push_back(int'(o_data2));
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: y = sat(floor((sum x[n-k]*c[k] + 2^14) / 2^15)).
    function automatic int model_out();
        int acc = 0;
        int idx;
        int r;
        for (int k = 0; k < 16; k++) begin
            idx = hist.size() - 1 - k;
            if (idx >= 0) acc += hist[idx] * coef[k];
        end
        r = (acc + 16384) >>> 15;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic do_reset();
        i_valid = 1'b0;
        i_data  = 8'd0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        n_in = 0;
        hist.delete();
        out_q.delete();
        out2_q.delete();
        ocyc_q.delete();
        trig_q.delete();
        exp_q.delete();
    endtask

    // Drive one sample now (at a falling edge); next sample gap cycles later.
    task automatic send(input int d, input int gap);
        i_data  = d[7:0];
        i_valid = 1'b1;
        n_in++;
        hist.push_back(d);
        if (n_in % 2 == 0) begin
            trig_q.push_back(cyc + 1);
            exp_q.push_back(8'(model_out()));
        end
        @(negedge clk);
        i_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic pad(input int n);
        while (out_q.size() < n) out_q.push_back(9999);
        while (out2_q.size() < n) out2_q.push_back(9999);
        while (ocyc_q.size() < n) ocyc_q.push_back(-9999);
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_data", int'(o_data), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_overrun", int'(o_overrun), 0);

        // DC input of 50 settles to 50 once the window is full
        for (int i = 0; i < 32; i++) send(50, 10);
        repeat (30) @(negedge clk);
        check("dc50_count", out_q.size(), 16);
        pad(16);
        for (int j = 7; j < 16; j++) check($sformatf("dc50_out%0d", j), out_q[j], 50);
        check("dc50_overrun", int'(o_overrun), 0);

        // Impulse of 64: output j = round(64*c[2j-1]/32768), latency 18
        do_reset();
        send(64, 10);
        for (int i = 0; i < 15; i++) send(0, 10);
        repeat (30) @(negedge clk);
        check("imp_count", out_q.size(), 8);
        pad(8);
        check("imp_out1", out_q[0], 0);
        check("imp_out2", out_q[1], 1);
        check("imp_out3", out_q[2], 4);
        check("imp_out4", out_q[3], 16);
        check("imp_out5", out_q[4], 10);
        check("imp_out6", out_q[5], 2);
        check("imp_out7", out_q[6], 0);
        check("imp_out8", out_q[7], 0);
        for (int j = 0; j < 8; j++) check($sformatf("imp_lat%0d", j), ocyc_q[j] - trig_q[j], 18);

        // Full-scale DC, unity gain and gain-2 (saturating) coefficient sets
        do_reset();
        for (int i = 0; i < 32; i++) send(127, 10);
        repeat (30) @(negedge clk);
        pad(16);
        check("sat_pos_unity", out_q[15], 127);
        check("sat_pos_gain2", out2_q[15], 127);
        for (int i = 0; i < 32; i++) send(-128, 10);
        repeat (30) @(negedge clk);
        pad(32);
        check("sat_neg_unity", out_q[31], -128);
        check("sat_neg_gain2", out2_q[31], -128);
        check("sat_overrun", int'(o_overrun), 0);

        // Back-to-back inputs: second trigger lands mid-MAC and is dropped
        do_reset();
        send(100, 1);
        send(100, 1);
        send(7, 1);
        send(7, 1);
        repeat (40) @(negedge clk);
        check("ovr_count", out_q.size(), 1);
        pad(1);
        check("ovr_first_out", out_q[0], -1);
        check("ovr_flag", int'(o_overrun), 1);
        send(7, 10);
        send(7, 10);
        repeat (30) @(negedge clk);
        check("ovr_sticky", int'(o_overrun), 1);
        check("ovr_resume_count", out_q.size(), 2);

        // Trigger spacing 18 is accepted
        do_reset();
        send(100, 1);
        send(100, 1);
        send(0, 17);
        send(0, 10);
        repeat (30) @(negedge clk);
        check("sp18_overrun", int'(o_overrun), 0);
        check("sp18_count", out_q.size(), 2);
        pad(2);
        check("sp18_out2", out_q[1], 2);

        // Trigger spacing 17 hits ROUND and is an overrun
        do_reset();
        send(100, 1);
        send(100, 1);
        send(0, 16);
        send(0, 10);
        repeat (30) @(negedge clk);
        check("sp17_overrun", int'(o_overrun), 1);
        check("sp17_count", out_q.size(), 1);

        // Reset during MAC abandons the result and clears history
        do_reset();
        send(5, 1);
        send(5, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_in = 0;
        hist.delete();
        repeat (30) @(negedge clk);
        check("rmid_no_out", out_q.size(), 0);
        send(100, 10);
        send(100, 10);
        repeat (30) @(negedge clk);
        check("rmid_count", out_q.size(), 1);
        pad(1);
        check("rmid_out", out_q[0], -1);
        check("rmid_overrun", int'(o_overrun), 0);

        // Long run at legal spacing; pointer wraps many times
        do_reset();
        for (int i = 0; i < 200; i++) begin
            send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(9, 12)));
        end
        repeat (30) @(negedge clk);
        check("rand_count", out_q.size(), 100);
        pad(100);
        for (int i = 0; i < 100; i++) begin
            check($sformatf("rand_out%0d", i), out_q[i], int'($signed(exp_q[i])));
        end
        check("rand_overrun", int'(o_overrun), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
